census_window_column: RTL and testbench
=======================================

// Module: census_window_column
// PURPOSE
//  Parametrised line-buffer/column former feeding the census (hamReg) stage, one per camera set.
//  Stores WINDOW-1 previous lines per channel in rotating line RAMs and emits, each pixel, a
//  full WINDOW-tall vertical column for each channel.
//  Replaces fixed 13-line wiring and bufif1 muxing with mux-based rotation, any WINDOW and
//  NUM_CH, line/frame tracking and a fill-qualified valid.
// PARAMETERS
//  PIXEL_DEPTH      18   pixel width minus 1
//  PX_CNT_DEPTH     9    pixel counter width minus 1
//  LINE_CNT_DEPTH   9    line counter width minus 1
//  PIXELS_PER_LINE  499  pixels per line minus 1 (line RAM depth = PIXELS_PER_LINE+1)
//  WINDOW           13   column height in pixels; legal 2..32
//  NUM_CH           2    independent channels sharing timing (L/R)
// PORTS
//  pxclk       in   1                          pixel clock, all logic rising-edge
//  reset       in   1                          synchronous, active-low
//  iHref       in   1                          line active; one pixel per pxclk while high
//  iVsync      in   1                          frame sync, high between frames
//  iData       in   NUM_CH*(PIXEL_DEPTH+1)     channel c at [c*(PIXEL_DEPTH+1) +: PIXEL_DEPTH+1]
//  oCol        out  NUM_CH*WINDOW*(PIXEL_DEPTH+1)  ch c, row r (0=oldest line) at (c*WINDOW+r)*(PIXEL_DEPTH+1)
//  oValid      out  1                          oCol holds a complete, in-frame column
//  oPxCount    out  PX_CNT_DEPTH+1             x of the pixel in row WINDOW-1 of oCol
//  oLineCount  out  LINE_CNT_DEPTH+1           y of the pixel in row WINDOW-1 of oCol
// BEHAVIOUR
//  Reset (reset==0 at an edge): oCol=0, oValid=0, oPxCount=0, oLineCount=0, FSM->S_WAIT_FRAME,
//   wp=0, fill=0, counters=0. RAM contents not cleared; fill gating hides stale data.
//  FSM: S_WAIT_FRAME -(iVsync==0 && iHref==1)-> S_LINE; S_LINE -(iHref==0)-> S_GAP;
//   S_GAP -(iHref==1)-> S_LINE; any state -(iVsync==1)-> S_WAIT_FRAME (highest priority,
//   also clears px/line counters, wp, fill). Only the first pixel of a line seen in
//   S_WAIT_FRAME/S_GAP is still captured (px=0) on the transition cycle.
//  Pixel counter px: 0 on first iHref cycle of a line, +1 per iHref cycle; saturates at
//   PIXELS_PER_LINE+1; pixels with px>PIXELS_PER_LINE are dropped (no write, no valid).
//  Line end (S_LINE->S_GAP): wp <= (wp==WINDOW-2)?0:wp+1; line <= line+1 (saturating at
//   all-ones); fill <= min(fill+1, WINDOW-1). A line of <1 pixel does not exist (no advance).
//  Per accepted pixel: all WINDOW-1 RAMs of each channel read at px; RAM[wp] written with iData
//   at px, read-before-write (old data returned). Row r<WINDOW-1 = RAM[(wp+r)%(WINDOW-1)],
//   row WINDOW-1 = iData registered one cycle.
//  Latency: exactly 1 pxclk from accepted pixel to oCol/oValid/oPxCount/oLineCount.
//  oValid = accepted-pixel delayed 1 && fill==WINDOW-1 (first valid on line WINDOW-1, x=0).
//   oCol/counts hold last value when oValid==0.
//  iHref drop mid-line: line ends at the last accepted pixel; remaining RAM words keep prior data.
//  iVsync rising during iHref: pixel on that cycle dropped; in-flight output still issued next cycle.
//  WINDOW==2: single RAM, wp stays 0.
// STRUCTURE
//  Shared header stereo_params.vh: clog2 function, pixel/column slice index macros, FSM
//   state encodings (S_WAIT_FRAME=0, S_LINE=1, S_GAP=2).
//  Sub-module line_ram: single-clock sync RAM, depth PIXELS_PER_LINE+1, width PIXEL_DEPTH+1,
//   1-cycle read, read-before-write; instantiated NUM_CH*(WINDOW-1) times via generate.
//  Top: FSM, counters, wp/fill, rotation mux (generate over ch,row), output registers.
// TESTING
//  Reset: drive reset=0 mid-line with iHref=1 -> next cycle oValid=0, oCol=0, counts 0; no valid
//   until WINDOW-1 new lines after reset.
//  Fill: WINDOW=3, PIXELS_PER_LINE=7, pixel=line*16+x -> first oValid at line 2 x=0 with
//   rows {0x00,0x10,0x20}; at line 4 x=5 rows {0x25,0x35,0x45}.
//  Rotation wrap: WINDOW=13, 20 lines -> every valid column rows are lines y-12..y in order across wp wrap.
//  Overlong/short line: 10 pixels with PIXELS_PER_LINE=7 -> x=8,9 produce no valid; a 4-pixel
//   line next -> x=4..7 rows retain older-line data, line counter still +1.
//  Vsync abort: assert iVsync mid-line 5 -> oValid low after the in-flight pixel, next frame
//   needs WINDOW-1 lines before oValid, oLineCount restarts 0.
//  Channels: NUM_CH=2, ch1=~ch0 -> ch1 column bitwise inverse of ch0 for every valid cycle.

Source files
------------

// File: rtl/census_window_column_pkg.sv
// Shared types and helpers for the census column former: FSM encoding and index sizing.
package census_window_column_pkg;

  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'd0,
    S_LINE       = 2'd1,
    S_GAP        = 2'd2
  } lineState_e;

  // Bits needed to index n items (0..n-1), never less than one.
  function automatic int idxWidth(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/census_window_column_line_ram.sv
// Single-clock line RAM with registered, read-before-write read port.
module census_window_column_line_ram #(
  parameter int DEPTH  = 500,
  parameter int WIDTH  = 19,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rdEn,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wrData,
  output logic [WIDTH-1:0]  rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wrEn) mem[addr] <= wrData;
  end

  // NOTE: non-blocking assignment here is what returns the old word when rdEn and wrEn coincide.
  always_ff @(posedge clk) begin
    if (!reset)    rdData <= '0;
    else if (rdEn) rdData <= mem[addr];
  end

endmodule

// File: rtl/census_window_column.sv
// Line buffer / column former: WINDOW-1 rotating line RAMs per channel plus the live pixel.
module census_window_column
  import census_window_column_pkg::*;
#(
  parameter int PIXEL_DEPTH     = 18,
  parameter int PX_CNT_DEPTH    = 9,
  parameter int LINE_CNT_DEPTH  = 9,
  parameter int PIXELS_PER_LINE = 499,
  parameter int WINDOW          = 13,
  parameter int NUM_CH          = 2
) (
  input  logic                                     pxclk,
  input  logic                                     reset,
  input  logic                                     iHref,
  input  logic                                     iVsync,
  input  logic [NUM_CH*(PIXEL_DEPTH+1)-1:0]        iData,
  output logic [NUM_CH*WINDOW*(PIXEL_DEPTH+1)-1:0] oCol,
  output logic                                     oValid,
  output logic [PX_CNT_DEPTH:0]                    oPxCount,
  output logic [LINE_CNT_DEPTH:0]                  oLineCount
);

  localparam int PW     = PIXEL_DEPTH + 1;
  localparam int PXW    = PX_CNT_DEPTH + 1;
  localparam int NRAM   = WINDOW - 1;
  localparam int WP_W   = idxWidth(NRAM);
  localparam int FILL_W = idxWidth(WINDOW);

  localparam logic [PXW-1:0]    PX_LAST   = PXW'(PIXELS_PER_LINE);
  localparam logic [PXW-1:0]    PX_SAT    = PXW'(PIXELS_PER_LINE + 1);
  localparam logic [WP_W-1:0]   WP_LAST   = WP_W'(NRAM - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WINDOW - 1);

  lineState_e state, stateNext;

  logic [PXW-1:0]            pxCnt, curPx;
  logic [LINE_CNT_DEPTH:0]   lineCnt;
  logic [WP_W-1:0]           wp, rowBase;
  logic [FILL_W-1:0]         fill;
  logic                      accept, lineEnd, emit;
  logic [NUM_CH*PW-1:0]      dataReg;
  logic [PW-1:0]             ramQ [NUM_CH][NRAM];

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    stateNext = state;
    curPx     = '0;
    accept    = 1'b0;
    lineEnd   = 1'b0;
    if (iVsync) begin
      stateNext = S_WAIT_FRAME;
    end else begin
      unique case (state)
        S_WAIT_FRAME, S_GAP: begin
          // The first pixel of a line is captured on the transition cycle itself.
          if (iHref) begin
            stateNext = S_LINE;
            accept    = 1'b1;
          end
        end
        S_LINE: begin
          if (iHref) begin
            curPx  = pxCnt;
            accept = (pxCnt <= PX_LAST);
          end else begin
            stateNext = S_GAP;
            lineEnd   = 1'b1;
          end
        end
        default: stateNext = S_WAIT_FRAME;
      endcase
    end
    emit = accept && (fill == FILL_FULL);
  end

  always_ff @(posedge pxclk) begin
    if (!reset) begin
      state   <= S_WAIT_FRAME;
      pxCnt   <= '0;
      lineCnt <= '0;
      wp      <= '0;
      fill    <= '0;
    end else begin
      state <= stateNext;
      if (iVsync) begin
        pxCnt   <= '0;
        lineCnt <= '0;
        wp      <= '0;
        fill    <= '0;
      end else begin
        if (iHref) pxCnt <= (curPx == PX_SAT) ? curPx : curPx + 1'b1;
        if (lineEnd) begin
          wp <= (wp == WP_LAST) ? '0 : wp + 1'b1;
          if (lineCnt != '1)       lineCnt <= lineCnt + 1'b1;
          if (fill != FILL_FULL)   fill    <= fill + 1'b1;
        end
      end
    end
  end

  // Output registers only move on an emitted column, so oCol and the counts hold otherwise.
  always_ff @(posedge pxclk) begin
    if (!reset) begin
      oValid     <= 1'b0;
      oPxCount   <= '0;
      oLineCount <= '0;
      rowBase    <= '0;
      dataReg    <= '0;
    end else begin
      oValid <= emit;
      if (emit) begin
        oPxCount   <= curPx;
        oLineCount <= lineCnt;
        rowBase    <= wp;
        dataReg    <= iData;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    for (genvar r = 0; r < NRAM; r++) begin : gRam
      census_window_column_line_ram #(
        .DEPTH (PIXELS_PER_LINE + 1),
        .WIDTH (PW),
        .ADDR_W(PXW)
      ) uRam (
        .clk   (pxclk),
        .reset (reset),
        .rdEn  (emit),
        .wrEn  (accept && (wp == WP_W'(r))),
        .addr  (curPx),
        .wrData(iData[c*PW +: PW]),
        .rdData(ramQ[c][r])
      );
    end
  end

  // Row r comes from the RAM written r lines after the one currently being overwritten.
  always_comb begin
    int sel;
    sel  = 0;
    oCol = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 0; r < NRAM; r++) begin
        sel = int'(rowBase) + r;
        if (sel >= NRAM) sel = sel - NRAM;
        oCol[(c*WINDOW + r)*PW +: PW] = ramQ[c][sel];
      end
      oCol[(c*WINDOW + NRAM)*PW +: PW] = dataReg[c*PW +: PW];
    end
  end

endmodule

// File: tb/tb_census_window_column.sv
// Directed bench: WINDOW=3 and WINDOW=13 instances share one stimulus stream.
module tb_census_window_column;

  localparam int PW  = 12;
  localparam int PPL = 7;
  localparam int WA  = 3;
  localparam int WB  = 13;
  localparam int NC  = 2;

  logic              pxclk = 1'b0;
  logic              reset, iHref, iVsync;
  logic [NC*PW-1:0]  iData;

  logic [NC*WA*PW-1:0] oColA;
  logic                oValidA;
  logic [9:0]          oPxA, oLineA;
  logic [NC*WB*PW-1:0] oColB;
  logic                oValidB;
  logic [9:0]          oPxB, oLineB;

  always #5 pxclk = ~pxclk;

  census_window_column #(
    .PIXEL_DEPTH(PW-1), .PX_CNT_DEPTH(9), .LINE_CNT_DEPTH(9),
    .PIXELS_PER_LINE(PPL), .WINDOW(WA), .NUM_CH(NC)
  ) dutA (
    .pxclk(pxclk), .reset(reset), .iHref(iHref), .iVsync(iVsync), .iData(iData),
    .oCol(oColA), .oValid(oValidA), .oPxCount(oPxA), .oLineCount(oLineA)
  );

  census_window_column #(
    .PIXEL_DEPTH(PW-1), .PX_CNT_DEPTH(9), .LINE_CNT_DEPTH(9),
    .PIXELS_PER_LINE(PPL), .WINDOW(WB), .NUM_CH(NC)
  ) dutB (
    .pxclk(pxclk), .reset(reset), .iHref(iHref), .iVsync(iVsync), .iData(iData),
    .oCol(oColB), .oValid(oValidB), .oPxCount(oPxB), .oLineCount(oLineB)
  );

  int tests = 0;
  int fails = 0;
  int fr    = 0;
  int base  = 0;
  int invBad = 0;
  int cntB   = 0;

  logic [WA*PW-1:0] obsA  [4][32][16];
  bit               seenA [4][32][16];
  int               cntA  [4][32];
  logic [WB*PW-1:0] obsB  [32][16];
  bit               seenB [32][16];

  typedef struct {
    int               fr;
    int               y;
    int               x;
    bit               expSeen;
    logic [WA*PW-1:0] expCol;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Record whatever column the DUTs present right now.
  task automatic sample();
    int y, x;
    if (oValidA) begin
      y = int'(oLineA);
      x = int'(oPxA);
      if (y < 32 && x < 16) begin
        obsA[fr][y][x]  = oColA[WA*PW-1:0];
        seenA[fr][y][x] = 1'b1;
      end
      cntA[fr][(y < 32) ? y : 31]++;
      if (oColA[2*WA*PW-1 -: WA*PW] !== ~oColA[WA*PW-1:0]) invBad++;
    end
    if (oValidB) begin
      y = int'(oLineB);
      x = int'(oPxB);
      if (fr == 0) begin
        cntB++;
        if (y < 32 && x < 16) begin
          obsB[y][x]  = oColB[WB*PW-1:0];
          seenB[y][x] = 1'b1;
        end
      end
      if (oColB[2*WB*PW-1 -: WB*PW] !== ~oColB[WB*PW-1:0]) invBad++;
    end
  endtask

  // Drive one cycle at a falling edge; outputs seen at the next falling edge belong to it.
  task automatic step(input logic href, input logic vsync, input logic rst, input logic [PW-1:0] pix);
    iHref  = href;
    iVsync = vsync;
    reset  = rst;
    iData  = {~pix, pix};
    @(negedge pxclk);
    sample();
  endtask

  function automatic logic [PW-1:0] pixAt(input int y, input int x);
    return PW'(base + y*16 + x);
  endfunction

  task automatic sendLine(input int y, input int n);
    for (int x = 0; x < n; x++) step(1'b1, 1'b0, 1'b1, pixAt(y, x));
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    int sum;
    logic [WB*PW-1:0] e;

    vecs[0]  = '{0,  1, 7, 1'b0, '0};
    vecs[1]  = '{0,  2, 0, 1'b1, {12'h020, 12'h010, 12'h000}};
    vecs[2]  = '{0,  4, 5, 1'b1, {12'h045, 12'h035, 12'h025}};
    vecs[3]  = '{0, 10, 3, 1'b1, {12'h0a3, 12'h093, 12'h083}};
    vecs[4]  = '{0, 19, 7, 1'b1, {12'h137, 12'h127, 12'h117}};
    vecs[5]  = '{1,  2, 7, 1'b1, {12'h827, 12'h817, 12'h807}};
    vecs[6]  = '{1,  2, 8, 1'b0, '0};
    vecs[7]  = '{1,  3, 3, 1'b1, {12'h833, 12'h823, 12'h813}};
    vecs[8]  = '{1,  3, 4, 1'b0, '0};
    vecs[9]  = '{1,  4, 0, 1'b1, {12'h840, 12'h830, 12'h820}};
    vecs[10] = '{1,  4, 5, 1'b1, {12'h845, 12'h815, 12'h825}};
    vecs[11] = '{2,  1, 7, 1'b0, '0};
    vecs[12] = '{2,  2, 0, 1'b1, {12'h420, 12'h410, 12'h400}};
    vecs[13] = '{3,  1, 5, 1'b0, '0};
    vecs[14] = '{3,  2, 0, 1'b1, {12'h220, 12'h210, 12'h200}};

    iHref = 1'b0; iVsync = 1'b1; reset = 1'b0; iData = '0;
    @(negedge pxclk);
    repeat (3) step(1'b0, 1'b1, 1'b0, '0);
    check("rstValidA", 192'(oValidA), 0);
    check("rstColA",   192'(oColA), 0);
    check("rstPxA",    192'(oPxA), 0);
    check("rstLineA",  192'(oLineA), 0);
    check("rstValidB", 192'(oValidB), 0);
    check("rstColB",   192'(|oColB), 0);

    step(1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Frame 0: 20 full lines for fill, rotation wrap and channel checks.
    fr = 0; base = 'h000;
    for (int y = 0; y < 20; y++) sendLine(y, 8);
    step(1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Frame 1: overlong line 2, short line 3, then a vsync abort in line 5.
    fr = 1; base = 'h800;
    sendLine(0, 8);
    sendLine(1, 8);
    sendLine(2, 10);
    sendLine(3, 4);
    sendLine(4, 8);
    for (int x = 0; x < 4; x++) step(1'b1, 1'b0, 1'b1, pixAt(5, x));
    check("abortInFlightValid", 192'(oValidA), 1);
    check("abortInFlightPx",    192'(oPxA), 3);
    check("abortInFlightLine",  192'(oLineA), 5);
    step(1'b1, 1'b1, 1'b1, pixAt(5, 4));
    check("abortValidLow", 192'(oValidA), 0);
    check("abortPxHold",   192'(oPxA), 3);
    step(1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b1, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Frame 2: refill after abort, then reset mid-line with iHref high.
    fr = 2; base = 'h400;
    for (int y = 0; y < 3; y++) sendLine(y, 8);
    for (int x = 0; x < 3; x++) step(1'b1, 1'b0, 1'b1, pixAt(3, x));
    step(1'b1, 1'b0, 1'b0, pixAt(3, 3));
    check("midRstValidA", 192'(oValidA), 0);
    check("midRstColA",   192'(oColA), 0);
    check("midRstPxA",    192'(oPxA), 0);
    check("midRstLineA",  192'(oLineA), 0);
    check("midRstColB",   192'(|oColB), 0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Post-reset lines without any vsync.
    fr = 3; base = 'h200;
    for (int y = 0; y < 3; y++) sendLine(y, 8);

    foreach (vecs[i]) begin
      check($sformatf("vec%0d_f%0d_y%0d_x%0d", i, vecs[i].fr, vecs[i].y, vecs[i].x),
            {seenA[vecs[i].fr][vecs[i].y][vecs[i].x],
             seenA[vecs[i].fr][vecs[i].y][vecs[i].x] ? obsA[vecs[i].fr][vecs[i].y][vecs[i].x] : '0},
            {vecs[i].expSeen, vecs[i].expCol});
    end

    sum = 0;
    for (int y = 0; y < 32; y++) sum += cntA[0][y];
    check("cntA_frame0",       192'(sum), 144);
    check("cntA_overlongLine", 192'(cntA[1][2]), 8);
    check("cntA_shortLine",    192'(cntA[1][3]), 4);
    check("cntA_abortLine",    192'(cntA[1][5]), 4);
    check("cntA_refillAbort",  192'(cntA[2][0] + cntA[2][1]), 0);
    check("cntA_refillReset",  192'(cntA[3][0] + cntA[3][1]), 0);
    check("cntB_frame0",       192'(cntB), 64);

    for (int y = 12; y < 20; y++) begin
      for (int x = 0; x < 8; x++) begin
        e = '0;
        for (int r = 0; r < WB; r++) e[r*PW +: PW] = PW'((y - 12 + r)*16 + x);
        check($sformatf("rotB_y%0d_x%0d", y, x), {seenB[y][x], obsB[y][x]}, {1'b1, e});
      end
    end

    check("chInverse", 192'(invBad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
